cpu_mem_responder: RTL and testbench

- Memory/I-O responder on the far end of the CPU bus (rd, wr, addr[12:0], bidirectional data[7:0]).
- Serves instruction/data reads from a loadable ROM region and reads/writes to a RAM region.
- Exposes one memory-mapped output port, buffered in a small FIFO with a valid/ready handshake toward an external consumer (testbench or console model).
- Sits beside the CPU at chip top; the CPU pins connect to it directly.

---
 rtl/cpu_bus_pkg.sv | 25 ++
 rtl/cpu_mem_responder_out_fifo.sv | 64 ++++++
 rtl/cpu_mem_responder.sv | 165 ++++++++++++++++
 tb/tb_cpu_mem_responder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Purpose : shared address map, status-byte layout and region type for the
//           CPU-side memory/IO responder.
// Contents: ROM_DEPTH, RAM_BASE, IO_ADDR, FIFO_DEPTH defaults,
//           status bit indices, region_t decode enum.
package cpu_bus_pkg;

    localparam int          ROM_DEPTH  = 6144;
    localparam logic [12:0] RAM_BASE   = 13'h1800;
    localparam logic [12:0] IO_ADDR    = 13'h1FFF;
    localparam int          FIFO_DEPTH = 8;

    // Bit positions inside the status byte returned by a read of IO_ADDR.
    localparam int ST_FULL     = 0;
    localparam int ST_BUS_ERR  = 1;
    localparam int ST_OVERFLOW = 2;
    localparam int ST_EMPTY    = 3;

    typedef enum logic [1:0] {
        REG_ROM  = 2'd0,
        REG_RAM  = 2'd1,
        REG_IO   = 2'd2,
        REG_NONE = 2'd3
    } region_t;

endpackage

// File: rtl/cpu_mem_responder_out_fifo.sv
// Purpose : synchronous byte FIFO buffering the memory-mapped output port.
// Ports   : clk, reset (sync, active-low)
//           i_push/i_data  - enqueue (ignored when full unless popping too)
//           i_pop          - dequeue (ignored when empty)
//           o_data         - head byte, 0 while empty
//           o_empty/o_full/o_count - occupancy
module out_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;

    assign w_pop_ok  = i_pop & ~o_empty;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    // Storage is not reset; o_data masks stale contents while empty.
    assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cpu_mem_responder.sv
// Purpose : far-end responder on the CPU bus. Serves a loadable ROM, a RAM
//           and one output port/status register; output bytes are queued in
//           out_fifo toward an external consumer.
// Ports   : clk, reset (sync, active-low)
//           rd, wr, addr, data (inout, driven only on valid reads)
//           load_en, load_addr, load_data - program load, overrides the bus
//           io_valid, io_data, io_ready   - output FIFO handshake
//           io_overflow, bus_err          - sticky error flags
module cpu_mem_responder #(
    parameter int          ROM_DEPTH  = cpu_bus_pkg::ROM_DEPTH,
    parameter logic [12:0] RAM_BASE   = cpu_bus_pkg::RAM_BASE,
    parameter logic [12:0] IO_ADDR    = cpu_bus_pkg::IO_ADDR,
    parameter int          FIFO_DEPTH = cpu_bus_pkg::FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [12:0] addr,
    inout  wire  [7:0]  data,
    input  logic        load_en,
    input  logic [12:0] load_addr,
    input  logic [7:0]  load_data,
    output logic        io_valid,
    output logic [7:0]  io_data,
    input  logic        io_ready,
    output logic        io_overflow,
    output logic        bus_err
);

    import cpu_bus_pkg::*;

    localparam int          RAM_DEPTH = int'(IO_ADDR) - int'(RAM_BASE);
    localparam int          RAM_AW    = $clog2(RAM_DEPTH);
    localparam int          ROM_AW    = $clog2(ROM_DEPTH);
    localparam int          CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [13:0] ROM_LIMIT = 14'(ROM_DEPTH);

    logic [7:0]       r_rom [ROM_DEPTH];
    logic [7:0]       r_ram [RAM_DEPTH];

    logic             r_rd_q;
    logic             r_wr_q;
    logic [7:0]       r_rdata;
    logic             r_bus_err;
    logic             r_io_overflow;

    region_t          w_region;
    region_t          w_load_region;
    logic [12:0]      w_ram_off;
    logic [12:0]      w_load_ram_off;
    logic             w_cpu_rd;
    logic             w_cpu_wr;
    logic             w_conflict;
    logic             w_push;
    logic             w_pop;
    logic             w_drive;
    logic [7:0]       w_status;
    logic [7:0]       w_rdata_next;
    logic             w_fifo_empty;
    logic             w_fifo_full;
    logic [CNT_W-1:0] w_fifo_count;

    function automatic region_t decode(input logic [12:0] a);
        if ({1'b0, a} < ROM_LIMIT)
            return REG_ROM;
        else if (a >= RAM_BASE && a < IO_ADDR)
            return REG_RAM;
        else if (a == IO_ADDR)
            return REG_IO;
        else
            return REG_NONE;
    endfunction

    assign w_region       = decode(addr);
    assign w_load_region  = decode(load_addr);
    assign w_ram_off      = addr - RAM_BASE;
    assign w_load_ram_off = load_addr - RAM_BASE;

    assign w_cpu_rd   = rd & ~wr & ~load_en;
    assign w_cpu_wr   = wr & ~rd & ~load_en;
    assign w_conflict = rd & wr & ~load_en;

    // Only the rising edge of wr pushes, so a strobe held for several
    // cycles enqueues a single byte. Gated by reset so the reset edge
    // never pushes.
    assign w_push = reset & w_cpu_wr & ~r_wr_q & (w_region == REG_IO);
    assign w_pop  = io_valid & io_ready;

    always_comb begin
        w_status              = 8'h00;
        w_status[ST_FULL]     = (w_fifo_count == CNT_W'(FIFO_DEPTH));
        w_status[ST_BUS_ERR]  = r_bus_err;
        w_status[ST_OVERFLOW] = r_io_overflow;
        w_status[ST_EMPTY]    = (w_fifo_count == '0);
    end

    always_comb begin
        w_rdata_next = 8'h00;
        case (w_region)
            REG_ROM:  w_rdata_next = r_rom[addr[ROM_AW-1:0]];
            REG_RAM:  w_rdata_next = r_ram[w_ram_off[RAM_AW-1:0]];
            REG_IO:   w_rdata_next = w_status;
            default:  w_rdata_next = 8'h00;
        endcase
    end

    // Reset is in the drive term so an interrupted read releases the bus
    // in the same cycle rather than one edge later.
    assign w_drive = reset & rd & r_rd_q & ~wr & ~load_en;
    assign data    = w_drive ? r_rdata : 8'hzz;

    // Memory arrays keep their contents across reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (load_en) begin
                if (w_load_region == REG_ROM)
                    r_rom[load_addr[ROM_AW-1:0]] <= load_data;
                else if (w_load_region == REG_RAM)
                    r_ram[w_load_ram_off[RAM_AW-1:0]] <= load_data;
            end else if (w_cpu_wr && w_region == REG_RAM) begin
                r_ram[w_ram_off[RAM_AW-1:0]] <= data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_q        <= 1'b0;
            r_wr_q        <= 1'b0;
            r_rdata       <= 8'h00;
            r_bus_err     <= 1'b0;
            r_io_overflow <= 1'b0;
        end else begin
            r_rd_q <= w_cpu_rd;
            r_wr_q <= wr;
            if (w_cpu_rd)
                r_rdata <= w_rdata_next;
            if ((w_cpu_wr && w_region == REG_ROM) || w_conflict)
                r_bus_err <= 1'b1;
            if (w_push && w_fifo_full && !w_pop)
                r_io_overflow <= 1'b1;
        end
    end

    out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_out_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (data),
        .i_pop   (w_pop),
        .o_data  (io_data),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full),
        .o_count (w_fifo_count)
    );

    assign io_valid    = ~w_fifo_empty;
    assign io_overflow = r_io_overflow;
    assign bus_err     = r_bus_err;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder. The data bus is a tri1 net, so a
// released (high-Z) bus reads back as 8'hFF; no read in this bench expects FF.
module tb_cpu_mem_responder;

    localparam logic [12:0] IO_A = 13'h1FFF;
    localparam logic [7:0]  ZV   = 8'hFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd;
    logic        wr;
    logic [12:0] addr;
    logic        load_en;
    logic [12:0] load_addr;
    logic [7:0]  load_data;
    logic        io_ready;
    logic        io_valid;
    logic [7:0]  io_data;
    logic        io_overflow;
    logic        bus_err;
    logic        tb_drv;
    logic [7:0]  tb_dat;
    tri1  [7:0]  data;

    int checks = 0;
    int errors = 0;

    assign data = tb_drv ? tb_dat : 8'hzz;

    always #5 clk = ~clk;

    cpu_mem_responder dut (
        .clk         (clk),
        .reset       (reset),
        .rd          (rd),
        .wr          (wr),
        .addr        (addr),
        .data        (data),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .io_valid    (io_valid),
        .io_data     (io_data),
        .io_ready    (io_ready),
        .io_overflow (io_overflow),
        .bus_err     (bus_err)
    );

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic load_byte(input logic [12:0] a, input logic [7:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        step();
        load_en   = 1'b0;
    endtask

    // Two-cycle read: the value is sampled in the second cycle of rd.
    task automatic cpu_read(input logic [12:0] a, output logic [7:0] v);
        addr = a;
        rd   = 1'b1;
        step();
        v    = data;
        rd   = 1'b0;
        #1;
    endtask

    task automatic cpu_write(input logic [12:0] a, input logic [7:0] d, input int n);
        addr   = a;
        tb_dat = d;
        tb_drv = 1'b1;
        wr     = 1'b1;
        repeat (n) step();
        wr     = 1'b0;
        tb_drv = 1'b0;
        step();
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] rom_img [4];
        rom_img[0] = 8'hA0;
        rom_img[1] = 8'h11;
        rom_img[2] = 8'hB2;
        rom_img[3] = 8'h33;

        reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        io_ready = 1'b0; tb_drv = 1'b0; tb_dat = '0;
        step();
        check_val("rst_io_valid", io_valid, 8'h00);
        check_val("rst_io_data", io_data, 8'h00);
        check_val("rst_overflow", io_overflow, 8'h00);
        check_val("rst_bus_err", bus_err, 8'h00);
        check_val("rst_data_z", data, ZV);
        reset = 1'b1;

        for (int i = 0; i < 4; i++) load_byte(13'(i), rom_img[i]);
        load_byte(13'h0010, 8'h00);

        addr = 13'h0002;
        rd   = 1'b1;
        #1;
        check_val("rom_rd_cyc1_z", data, ZV);
        step();
        check_val("rom_rd_cyc2", data, 8'hB2);
        rd = 1'b0;
        #1;
        check_val("rom_rd_drop_z", data, ZV);
        cpu_read(13'h0000, v); check_val("rom_rd_0", v, 8'hA0);
        cpu_read(13'h0003, v); check_val("rom_rd_3", v, 8'h33);

        cpu_write(13'h1800, 8'h5A, 3);
        check_val("ram_wr_no_err", bus_err, 8'h00);
        cpu_read(13'h1800, v); check_val("ram_rd", v, 8'h5A);

        cpu_write(13'h0010, 8'hFF, 1);
        check_val("rom_wr_bus_err", bus_err, 8'h01);
        cpu_read(13'h0010, v); check_val("rom_unchanged", v, 8'h00);

        cpu_write(IO_A, 8'h41, 4);
        check_val("io_held_valid", io_valid, 8'h01);
        check_val("io_held_data", io_data, 8'h41);
        io_ready = 1'b1;
        step();
        io_ready = 1'b0;
        check_val("io_single_entry", io_valid, 8'h00);

        do_reset();
        check_val("rst2_bus_err", bus_err, 8'h00);
        for (int i = 1; i <= 9; i++) cpu_write(IO_A, 8'(i), 1);
        check_val("ovf_flag", io_overflow, 8'h01);
        check_val("ovf_head", io_data, 8'h01);
        cpu_read(IO_A, v); check_val("status_full_ovf", v, 8'h05);
        io_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check_val("drain", io_data, 8'(i));
            step();
        end
        io_ready = 1'b0;
        check_val("drained_valid", io_valid, 8'h00);
        cpu_read(IO_A, v); check_val("status_empty_ovf", v, 8'h0C);

        addr = 13'h1800; rd = 1'b1; wr = 1'b1; tb_drv = 1'b0;
        step();
        check_val("conflict_z", data, ZV);
        check_val("conflict_bus_err", bus_err, 8'h01);
        rd = 1'b0; wr = 1'b0;
        step();
        cpu_read(13'h1800, v); check_val("conflict_ram_kept", v, 8'h5A);

        do_reset();
        check_val("rst3_overflow", io_overflow, 8'h00);
        check_val("rst3_bus_err", bus_err, 8'h00);
        check_val("rst3_io_valid", io_valid, 8'h00);
        cpu_read(13'h1800, v); check_val("rst3_ram_kept", v, 8'h5A);
        cpu_read(IO_A, v); check_val("rst3_status", v, 8'h08);

        addr = 13'h0002; rd = 1'b1;
        step();
        check_val("midrd_data", data, 8'hB2);
        reset = 1'b0;
        #1;
        check_val("midrd_rst_z", data, ZV);
        step();
        reset = 1'b1;
        #1;
        check_val("midrd_after_z", data, ZV);
        rd = 1'b0;
        addr = IO_A; tb_dat = 8'h77; tb_drv = 1'b1; wr = 1'b1; reset = 1'b0;
        step();
        wr = 1'b0; tb_drv = 1'b0; reset = 1'b1;
        step();
        check_val("midwr_no_push", io_valid, 8'h00);

        for (int i = 0; i < 8; i++) cpu_write(IO_A, 8'h10 + 8'(i), 1);
        addr = IO_A; tb_dat = 8'h18; tb_drv = 1'b1; wr = 1'b1; io_ready = 1'b1;
        step();
        wr = 1'b0; tb_drv = 1'b0; io_ready = 1'b0;
        step();
        check_val("pp_no_ovf", io_overflow, 8'h00);
        check_val("pp_head", io_data, 8'h11);
        cpu_read(IO_A, v); check_val("pp_status_full", v, 8'h01);
        io_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check_val("pp_drain", io_data, 8'h10 + 8'(i));
            step();
        end
        io_ready = 1'b0;
        check_val("pp_empty", io_valid, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
